// File: rtl/nav_pkg.sv
// Shared types, speed constants and saturating helpers for the navigation controller.
// FAST_SIM_EN scales the ramp steps and shortens heading settle for quick system sims.
package nav_pkg;

    localparam int unsigned SPD_W = 11;

    localparam logic [SPD_W-1:0] MIN_FRWRD = 11'h0D0;
    localparam logic [SPD_W-1:0] MAX_FRWRD = 11'h2A0;
    localparam logic [SPD_W-1:0] FRWRD_INC = 11'h002;
    localparam logic [SPD_W-1:0] FUSION_THR = MAX_FRWRD >> 1;

`ifdef FAST_SIM_EN
    localparam logic [SPD_W-1:0] ACC_STEP   = SPD_W'(8 * FRWRD_INC);
    localparam logic [SPD_W-1:0] DEC_STEP   = SPD_W'(16 * FRWRD_INC);
    localparam logic [SPD_W-1:0] DECF_STEP  = SPD_W'(64 * FRWRD_INC);
    localparam int unsigned      SETTLE_CYC = 2;
`else
    localparam logic [SPD_W-1:0] ACC_STEP   = FRWRD_INC;
    localparam logic [SPD_W-1:0] DEC_STEP   = SPD_W'(2 * FRWRD_INC);
    localparam logic [SPD_W-1:0] DECF_STEP  = SPD_W'(8 * FRWRD_INC);
    localparam int unsigned      SETTLE_CYC = 4;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StHeadng,
        StMove,
        StDecel,
        StDecelFast
    } nav_state_t;

    function automatic logic [SPD_W-1:0] sat_add(input logic [SPD_W-1:0] a,
                                                 input logic [SPD_W-1:0] b,
                                                 input logic [SPD_W-1:0] lim);
        logic [SPD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[SPD_W-1:0];
    endfunction

    function automatic logic [SPD_W-1:0] sat_sub(input logic [SPD_W-1:0] a,
                                                 input logic [SPD_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/nav_edge_det.sv
// Rising-edge detector against the previous cycle's sample.
// History resets high so a signal already high out of reset is not seen as an edge.
module nav_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= sig;
        end
    end

    assign rise = sig & ~hist_q;

endmodule

// File: rtl/navigate_ctrl.sv
// Command-side controller for the heading PID: heading turns, forward moves with speed ramps,
// opening/obstacle stops and completion pulses. Build option FAST_SIM_EN (see nav_pkg).
module navigate_ctrl
    import nav_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    strt_hdng,
    input  logic                    strt_mv,
    input  logic signed [11:0]      cmd_hdng,
    input  logic                    stp_lft,
    input  logic                    stp_rght,
    input  logic                    lft_opn,
    input  logic                    rght_opn,
    input  logic                    frwrd_opn,
    input  logic                    at_hdng,
    output logic                    moving,
    output logic signed [11:0]      dsrd_hdng,
    output logic [SPD_W-1:0]        frwrd_spd,
    output logic                    mv_cmplt,
    output logic                    en_fusion
);

    nav_state_t state_q, state_d;

    logic signed [11:0] dsrd_hdng_q, dsrd_hdng_d;
    logic [SPD_W-1:0]   frwrd_spd_q, frwrd_spd_d;
    logic [2:0]         settle_cnt_q, settle_cnt_d;
    logic               stp_lft_q, stp_lft_d;
    logic               stp_rght_q, stp_rght_d;
    logic               mv_cmplt_q, mv_cmplt_d;
    logic               en_fusion_q;

    logic lft_rise, rght_rise;
    logic settle_done, side_stop, decel_zero;
    logic [SPD_W-1:0] decel_spd;

    nav_edge_det u_lft_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (lft_opn),
        .rise  (lft_rise)
    );

    nav_edge_det u_rght_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (rght_opn),
        .rise  (rght_rise)
    );

    assign settle_done = (settle_cnt_q == 3'(SETTLE_CYC));
    assign side_stop   = (lft_rise & stp_lft_q) | (rght_rise & stp_rght_q);
    assign decel_spd   = sat_sub(frwrd_spd_q,
                                 (state_q == StDecelFast) ? DECF_STEP : DEC_STEP);
    assign decel_zero  = (decel_spd == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (strt_hdng) begin
                    state_d = StHeadng;
                end else if (strt_mv) begin
                    state_d = StMove;
                end
            end
            StHeadng: begin
                if (settle_done && at_hdng) begin
                    state_d = StIdle;
                end
            end
            StMove: begin
                if (!frwrd_opn) begin
                    state_d = StDecelFast;
                end else if (side_stop) begin
                    state_d = StDecel;
                end
            end
            StDecel: begin
                // Reaching zero ends the move even if the obstacle shows up this cycle
                if (decel_zero) begin
                    state_d = StIdle;
                end else if (!frwrd_opn) begin
                    state_d = StDecelFast;
                end
            end
            StDecelFast: begin
                if (decel_zero) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dsrd_hdng_d  = dsrd_hdng_q;
        frwrd_spd_d  = frwrd_spd_q;
        settle_cnt_d = settle_cnt_q;
        stp_lft_d    = stp_lft_q;
        stp_rght_d   = stp_rght_q;
        mv_cmplt_d   = (state_q != StIdle) && (state_d == StIdle);
        case (state_q)
            StIdle: begin
                if (strt_hdng) begin
                    dsrd_hdng_d  = cmd_hdng;
                    settle_cnt_d = '0;
                end else if (strt_mv) begin
                    frwrd_spd_d = MIN_FRWRD;
                    stp_lft_d   = stp_lft;
                    stp_rght_d  = stp_rght;
                end
            end
            StHeadng: begin
                if (!settle_done) begin
                    settle_cnt_d = settle_cnt_q + 3'd1;
                end
            end
            StMove:                frwrd_spd_d = sat_add(frwrd_spd_q, ACC_STEP, MAX_FRWRD);
            StDecel, StDecelFast:  frwrd_spd_d = decel_spd;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsrd_hdng_q  <= '0;
            frwrd_spd_q  <= '0;
            settle_cnt_q <= '0;
            stp_lft_q    <= 1'b0;
            stp_rght_q   <= 1'b0;
            mv_cmplt_q   <= 1'b0;
            en_fusion_q  <= 1'b0;
        end else begin
            dsrd_hdng_q  <= dsrd_hdng_d;
            frwrd_spd_q  <= frwrd_spd_d;
            settle_cnt_q <= settle_cnt_d;
            stp_lft_q    <= stp_lft_d;
            stp_rght_q   <= stp_rght_d;
            mv_cmplt_q   <= mv_cmplt_d;
            en_fusion_q  <= (frwrd_spd_q > FUSION_THR);
        end
    end

    assign moving    = (state_q != StIdle);
    assign dsrd_hdng = dsrd_hdng_q;
    assign frwrd_spd = frwrd_spd_q;
    assign mv_cmplt  = mv_cmplt_q;
    assign en_fusion = en_fusion_q;

endmodule

// File: tb/tb_navigate_ctrl.sv
// Directed self-checking bench for navigate_ctrl; expected steps follow FAST_SIM_EN if defined.
module tb_navigate_ctrl;

`ifdef FAST_SIM_EN
    localparam int ACC = 16, DEC = 32, DECF = 128, SETTLE = 2;
`else
    localparam int ACC = 2, DEC = 4, DECF = 16, SETTLE = 4;
`endif
    localparam int MIN_SPD = 'h0D0, MAX_SPD = 'h2A0, HALF = 'h150;
    localparam int SAT_CYC = (MAX_SPD - MIN_SPD + ACC - 1) / ACC;
    localparam int RST_CYC = (HALF - MIN_SPD) / ACC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strt_hdng = 1'b0, strt_mv = 1'b0;
    logic [11:0] cmd_hdng = '0;
    logic        stp_lft = 1'b0, stp_rght = 1'b0;
    logic        lft_opn = 1'b0, rght_opn = 1'b0, frwrd_opn = 1'b1, at_hdng = 1'b0;
    logic        moving, mv_cmplt, en_fusion;
    logic [11:0] dsrd_hdng;
    logic [10:0] frwrd_spd;

    int n_cmp = 0, n_err = 0;
    int exp_spd = 0;
    int exp_fus = 0;

    navigate_ctrl u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_hdng (strt_hdng),
        .strt_mv   (strt_mv),
        .cmd_hdng  (cmd_hdng),
        .stp_lft   (stp_lft),
        .stp_rght  (stp_rght),
        .lft_opn   (lft_opn),
        .rght_opn  (rght_opn),
        .frwrd_opn (frwrd_opn),
        .at_hdng   (at_hdng),
        .moving    (moving),
        .dsrd_hdng (dsrd_hdng),
        .frwrd_spd (frwrd_spd),
        .mv_cmplt  (mv_cmplt),
        .en_fusion (en_fusion)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One clock in MOVE: speed climbs by ACC, fusion flag reflects the previous speed
    task automatic ramp(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            exp_fus = (exp_spd > HALF) ? 1 : 0;
            exp_spd = (exp_spd + ACC > MAX_SPD) ? MAX_SPD : exp_spd + ACC;
            check_eq({tag, "_spd"}, 32'(frwrd_spd), exp_spd);
            check_eq({tag, "_fus"}, 32'(en_fusion), exp_fus);
        end
    endtask

    task automatic decel_n(input int step, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            exp_spd = (exp_spd > step) ? exp_spd - step : 0;
            check_eq({tag, "_spd"}, 32'(frwrd_spd), exp_spd);
            check_eq({tag, "_mv"}, 32'(moving), 1);
        end
    endtask

    task automatic decel_zero(input int step, input string tag);
        for (int i = 0; i < 400; i++) begin
            tick();
            exp_spd = (exp_spd > step) ? exp_spd - step : 0;
            check_eq({tag, "_spd"}, 32'(frwrd_spd), exp_spd);
            if (exp_spd == 0) begin
                check_eq({tag, "_cmplt"}, 32'(mv_cmplt), 1);
                check_eq({tag, "_mvlow"}, 32'(moving), 0);
                break;
            end
            check_eq({tag, "_nocmplt"}, 32'(mv_cmplt), 0);
        end
        tick();
        exp_fus = 0;
        check_eq({tag, "_onepulse"}, 32'(mv_cmplt), 0);
        check_eq({tag, "_idle_spd"}, 32'(frwrd_spd), 0);
    endtask

    task automatic start_move(input logic sl, input logic sr, input string tag);
        stp_lft = sl;
        stp_rght = sr;
        strt_mv = 1'b1;
        tick();
        strt_mv = 1'b0;
        stp_lft = 1'b0;
        stp_rght = 1'b0;
        exp_spd = MIN_SPD;
        check_eq({tag, "_start_spd"}, 32'(frwrd_spd), MIN_SPD);
        check_eq({tag, "_start_mv"}, 32'(moving), 1);
    endtask

    task automatic heading(input logic [11:0] hd, input logic also_mv, input string tag);
        cmd_hdng = hd;
        at_hdng = 1'b1;
        strt_hdng = 1'b1;
        strt_mv = also_mv;
        tick();
        strt_hdng = 1'b0;
        strt_mv = 1'b0;
        check_eq({tag, "_mv"}, 32'(moving), 1);
        check_eq({tag, "_hdng"}, 32'(dsrd_hdng), 32'(hd));
        check_eq({tag, "_spd0"}, 32'(frwrd_spd), 0);
        for (int i = 0; i < SETTLE; i++) begin
            tick();
            check_eq({tag, "_settle"}, 32'(mv_cmplt), 0);
            check_eq({tag, "_settle_mv"}, 32'(moving), 1);
        end
        tick();
        check_eq({tag, "_cmplt"}, 32'(mv_cmplt), 1);
        check_eq({tag, "_mvlow"}, 32'(moving), 0);
        tick();
        at_hdng = 1'b0;
        check_eq({tag, "_onepulse"}, 32'(mv_cmplt), 0);
        check_eq({tag, "_hold"}, 32'(dsrd_hdng), 32'(hd));
    endtask

    initial begin
        #1;
        check_eq("rst_mv", 32'(moving), 0);
        check_eq("rst_spd", 32'(frwrd_spd), 0);
        check_eq("rst_hdng", 32'(dsrd_hdng), 0);
        check_eq("rst_cmplt", 32'(mv_cmplt), 0);
        check_eq("rst_fus", 32'(en_fusion), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Heading with at_hdng already true
        heading(12'h3FF, 1'b0, "hdng");

        // Full ramp to saturation, then obstacle stop from cruise
        start_move(1'b0, 1'b0, "ramp");
        ramp(SAT_CYC + 3, "ramp");
        check_eq("ramp_cruise", 32'(frwrd_spd), MAX_SPD);
        check_eq("ramp_fus_on", 32'(en_fusion), 1);
        frwrd_opn = 1'b0;
        ramp(1, "obst_edge");
        decel_zero(DECF, "obst");
        frwrd_opn = 1'b1;

        // Left opening stop with stp_lft registered at start
        start_move(1'b1, 1'b0, "lft");
        ramp(SAT_CYC + 2, "lft");
        lft_opn = 1'b1;
        ramp(1, "lft_edge");
        decel_zero(DEC, "lft_dec");
        lft_opn = 1'b0;

        // Left opening without stp_lft must not stop; starts during the move are ignored
        start_move(1'b0, 1'b0, "nolft");
        ramp(SAT_CYC + 2, "nolft");
        lft_opn = 1'b1;
        ramp(4, "nolft_run");
        cmd_hdng = 12'h123;
        strt_hdng = 1'b1;
        strt_mv = 1'b1;
        ramp(1, "ign_start");
        strt_hdng = 1'b0;
        strt_mv = 1'b0;
        check_eq("ign_hdng", 32'(dsrd_hdng), 32'h3FF);
        check_eq("ign_mv", 32'(moving), 1);
        frwrd_opn = 1'b0;
        ramp(1, "nolft_obst");
        decel_zero(DECF, "nolft_dec");
        frwrd_opn = 1'b1;
        lft_opn = 1'b0;

        // Right opening stop, obstacle mid-decel switches to fast decel
        start_move(1'b0, 1'b1, "rght");
        ramp(20, "rght");
        rght_opn = 1'b1;
        ramp(1, "rght_edge");
        decel_n(DEC, 3, "rght_dec");
        frwrd_opn = 1'b0;
        decel_n(DEC, 1, "rght_sw");
        decel_zero(DECF, "rght_fast");
        frwrd_opn = 1'b1;
        rght_opn = 1'b0;

        // Obstacle at low speed: clamps to zero without wrap
        start_move(1'b0, 1'b0, "low");
        ramp(10, "low");
`ifndef FAST_SIM_EN
        check_eq("low_e4", 32'(frwrd_spd), 32'h0E4);
`endif
        frwrd_opn = 1'b0;
        ramp(1, "low_edge");
        decel_zero(DECF, "low_dec");
        frwrd_opn = 1'b1;

        // Simultaneous starts: heading wins
        heading(12'h800, 1'b1, "both");

        // Asynchronous reset mid-move
        start_move(1'b0, 1'b0, "rmid");
        ramp(RST_CYC, "rmid");
        check_eq("rmid_150", 32'(frwrd_spd), 32'h150);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rmid_mv", 32'(moving), 0);
        check_eq("rmid_spd", 32'(frwrd_spd), 0);
        check_eq("rmid_hdng", 32'(dsrd_hdng), 0);
        check_eq("rmid_fus", 32'(en_fusion), 0);
        check_eq("rmid_cmplt", 32'(mv_cmplt), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("rrel_mv", 32'(moving), 0);
        check_eq("rrel_cmplt", 32'(mv_cmplt), 0);
        check_eq("rrel_spd", 32'(frwrd_spd), 0);
        exp_spd = 0;
        start_move(1'b0, 1'b0, "rrel");
        frwrd_opn = 1'b0;
        ramp(1, "rrel_edge");
        decel_zero(DECF, "rrel_dec");
        frwrd_opn = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
